// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - PLL reset/lock sequencing and dynamic fine-phase-shift controller
// Optional feature macro: PLL_CTRL_LOCKLOSS_RECOVER_EN (lock loss in IDLE triggers a full re-lock).
module pll_phase_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int STEP_GAP     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic [2:0] phase_sel,
    output logic       phase_dir,
    output logic       phase_step_n,
    output logic       load_phase,
    output logic       locked,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_IDLE,
        S_SETUP,
        S_STEP_LO,
        S_STEP_HI,
        S_LOAD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  rem_q, rem_d;
    logic        lock_meta_q, lock_s_q;
    logic        pll_rst_q, pll_rst_d;
    logic [2:0]  phase_sel_q, phase_sel_d;
    logic        phase_dir_q, phase_dir_d;
    logic        step_n_q, step_n_d;
    logic        load_q, load_d;
    logic        ready_q, ready_d;
    logic        locked_q, locked_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        pll_rst_d   = pll_rst_q;
        phase_sel_d = phase_sel_q;
        phase_dir_d = phase_dir_q;
        step_n_d    = 1'b1;
        load_d      = 1'b0;
        ready_d     = ready_q;
        locked_d    = locked_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_RESET: begin
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    state_d   = S_WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    ready_d  = 1'b1;
                    locked_d = 1'b1;
                end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
                    state_d   = S_RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
`ifdef PLL_CTRL_LOCKLOSS_RECOVER_EN
                if (!lock_s_q) begin
                    state_d   = S_RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    ready_d   = 1'b0;
                    locked_d  = 1'b0;
                    err_d     = 1'b1;
                end else if (req_valid) begin
`else
                locked_d = lock_s_q;
                if (!lock_s_q) begin
                    err_d = 1'b1;
                end
                if (req_valid) begin
`endif
                    if (req_sel > 3'd4) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (req_steps == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = S_SETUP;
                        phase_sel_d = req_sel;
                        phase_dir_d = req_dir;
                        rem_d       = req_steps;
                        ready_d     = 1'b0;
                    end
                end
            end
            S_SETUP: begin
                state_d  = S_STEP_LO;
                step_n_d = 1'b0;
            end
            S_STEP_LO: begin
                if (rem_q != 8'd0) begin
                    rem_d = rem_q - 8'd1;
                end
                state_d = S_STEP_HI;
                cnt_d   = '0;
            end
            S_STEP_HI: begin
                if (cnt_q == 32'(STEP_GAP - 1)) begin
                    cnt_d = '0;
                    if (rem_q != 8'd0) begin
                        state_d  = S_STEP_LO;
                        step_n_d = 1'b0;
                    end else begin
                        state_d = S_LOAD;
                        load_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d   = S_RESET;
                cnt_d     = '0;
                pll_rst_d = 1'b1;
            end
        endcase

        // Losing lock mid-shift leaves the PLL in an unknown phase, so force a full re-lock.
        if ((state_q == S_SETUP || state_q == S_STEP_LO || state_q == S_STEP_HI ||
             state_q == S_LOAD) && !lock_s_q) begin
            state_d   = S_RESET;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            step_n_d  = 1'b1;
            load_d    = 1'b0;
            done_d    = 1'b0;
            ready_d   = 1'b0;
            locked_d  = 1'b0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            rem_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            phase_sel_q <= '0;
            phase_dir_q <= 1'b0;
            step_n_q    <= 1'b1;
            load_q      <= 1'b0;
            ready_q     <= 1'b0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            pll_rst_q   <= pll_rst_d;
            phase_sel_q <= phase_sel_d;
            phase_dir_q <= phase_dir_d;
            step_n_q    <= step_n_d;
            load_q      <= load_d;
            ready_q     <= ready_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready    = ready_q;
    assign pll_rst      = pll_rst_q;
    assign phase_sel    = phase_sel_q;
    assign phase_dir    = phase_dir_q;
    assign phase_step_n = step_n_q;
    assign load_phase   = load_q;
    assign locked       = locked_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb/tb_pll_phase_ctrl.sv - directed self-checking bench for pll_phase_ctrl
module tb_pll_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_sel = '0;
    logic       req_dir = 1'b0;
    logic [7:0] req_steps = '0;
    logic       pll_lock = 1'b0;
    logic       pll_rst;
    logic [2:0] phase_sel;
    logic       phase_dir;
    logic       phase_step_n;
    logic       load_phase;
    logic       locked;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    int n_low, n_load, n_done, load_cyc, done_cyc, sel_bad;
    int low_cyc [0:15];

    pll_phase_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dir     (req_dir),
        .req_steps   (req_steps),
        .pll_lock    (pll_lock),
        .pll_rst     (pll_rst),
        .phase_sel   (phase_sel),
        .phase_dir   (phase_dir),
        .phase_step_n(phase_step_n),
        .load_phase  (load_phase),
        .locked      (locked),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // Issue one request at a negedge, then scramble the inputs to prove they were latched.
    task automatic issue(input logic [2:0] s, input logic d, input logic [7:0] n);
        req_valid = 1'b1;
        req_sel   = s;
        req_dir   = d;
        req_steps = n;
        @(negedge clk);
        req_valid = 1'b0;
        req_sel   = 3'd1;
        req_dir   = ~d;
        req_steps = 8'd7;
    endtask

    // Sample cycles 0..ncyc-1 after acceptance; optionally drop pll_lock after a given low pulse.
    task automatic observe(input int ncyc, input logic [2:0] exp_sel, input logic exp_dir,
                           input int drop_after);
        n_low = 0; n_load = 0; n_done = 0; load_cyc = -1; done_cyc = -1; sel_bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (phase_step_n === 1'b0) begin
                if (n_low < 16) low_cyc[n_low] = i;
                n_low++;
                if (phase_sel !== exp_sel || phase_dir !== exp_dir) sel_bad++;
                if (drop_after > 0 && n_low == drop_after) pll_lock = 1'b0;
            end
            if (load_phase === 1'b1) begin
                n_load++;
                load_cyc = i;
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc = i;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int k;

        // Reset state and pll_rst pulse width
        pll_lock = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_step_n", phase_step_n, 1);
        check("rst_load", load_phase, 0);
        check("rst_ready", req_ready, 0);
        check("rst_locked", locked, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            if (pll_rst === 1'b1) k++;
            @(negedge clk);
        end
        check("pll_rst_cycles", k, 16);
        check("wait_err", err, 0);

        // Lock rises; IDLE must appear 2-3 cycles later
        pll_lock = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("lock_to_ready_in_2_3", (k >= 2 && k <= 3) ? 1 : 0, 1);
        check("locked_idle", locked, 1);

        // sel=2 dir=1 steps=3
        issue(3'd2, 1'b1, 8'd3);
        observe(25, 3'd2, 1'b1, 0);
        check("s3_lows", n_low, 3);
        check("s3_low0", low_cyc[0], 1);
        check("s3_gap1", low_cyc[1] - low_cyc[0], 5);
        check("s3_gap2", low_cyc[2] - low_cyc[1], 5);
        check("s3_sel_dir", sel_bad, 0);
        check("s3_loads", n_load, 1);
        check("s3_load_cyc", load_cyc, 16);
        check("s3_dones", n_done, 1);
        check("s3_done_cyc", done_cyc, 17);
        check("s3_err", err, 0);
        check("s3_ready", req_ready, 1);

        // steps=0, then sel=5
        issue(3'd3, 1'b0, 8'd0);
        observe(8, 3'd3, 1'b0, 0);
        check("z_done_cyc", done_cyc, 0);
        check("z_dones", n_done, 1);
        check("z_strobes", n_low + n_load, 0);
        check("z_err", err, 0);
        issue(3'd5, 1'b1, 8'd3);
        observe(8, 3'd5, 1'b1, 0);
        check("bad_sel_dones", n_done, 1);
        check("bad_sel_strobes", n_low + n_load, 0);
        check("bad_sel_err", err, 1);

        // Clear err, relock, then drop lock during step 2 of 10
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready("relock1");
        check("relock1_err", err, 0);
        issue(3'd4, 1'b0, 8'd10);
        observe(20, 3'd4, 1'b0, 2);
        check("drop_lows", n_low, 2);
        check("drop_dones", n_done, 0);
        check("drop_loads", n_load, 0);
        check("drop_err", err, 1);
        check("drop_pll_rst", pll_rst, 1);
        check("drop_locked", locked, 0);

        // Relock, then rst mid-request
        pll_lock = 1'b1;
        wait_ready("relock2");
        issue(3'd1, 1'b1, 8'd10);
        observe(4, 3'd1, 1'b1, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_pll_rst", pll_rst, 1);
        check("mid_step_n", phase_step_n, 1);
        check("mid_load", load_phase, 0);
        check("mid_sel", phase_sel, 0);
        check("mid_dir", phase_dir, 0);
        check("mid_ready", req_ready, 0);
        check("mid_locked", locked, 0);
        check("mid_done", done, 0);
        check("mid_err", err, 0);

        // Lock never arrives: timeout after LOCK_TIMEOUT cycles in WAIT_LOCK
        pll_lock = 1'b0;
        rst = 1'b0;
        k = 0;
        while (pll_rst !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("to_enter_wait", (k < 40) ? 1 : 0, 1);
        k = 0;
        while (pll_rst === 1'b0 && k < 70000) begin
            check_err_low: if (k == 65000) check("to_err_before", err, 0);
            @(negedge clk);
            k++;
        end
        check("to_wait_cycles", k, 65535);
        check("to_err", err, 1);
        check("to_pll_rst", pll_rst, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
